// File: rtl/pulse_scheduler_pkg.sv
// Shared types for pulse_scheduler.
//   ps_state_t : scheduler FSM encoding
//   GAP_W      : width of the enforced-idle-gap counter (MIN_GAP up to 255)
package pulse_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } ps_state_t;

  localparam int GAP_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req  : request vector
//   last : index served most recently; search starts at last+1 and wraps
//   any  : at least one request present
//   sel  : chosen index (0 when any=0)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] sel
);

  localparam int IDW = $clog2(N);
  localparam int unsigned NU = N;

  logic [IDW-1:0] idx;

  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = IDW'((32'(last) + k) % NU);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Rising-edge event collector and round-robin scheduler for a single consumer.
//   clk, rst          : clock, synchronous active-high reset
//   din[N]            : synchronous level inputs; 0->1 is an event
//   ev_valid, ev_id   : registered offer of one pending source
//   ev_ready          : consumer accept; handshake = ev_valid & ev_ready
//   pending[N]        : per-source pending flags
//   overrun, ovr_id   : one-cycle pulse and lowest index of a dropped event
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int N       = 4,
  parameter int MIN_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         din,
  output logic                 ev_valid,
  output logic [$clog2(N)-1:0] ev_id,
  input  logic                 ev_ready,
  output logic [N-1:0]         pending,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] ovr_id
);

  localparam int IDW = $clog2(N);
  localparam int unsigned NU = N;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

  logic [N-1:0]     q1, q2, rise, clr, lost;
  logic             handshake;
  logic             any;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   ovr_id_n;

  ps_state_t        state, state_n;
  logic [IDW-1:0]   ev_id_n, last, last_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;

  assign rise      = q1 & ~q2;
  assign handshake = ev_valid & ev_ready;

  // A rise on a source being cleared this cycle re-arms it instead of being lost.
  always_comb begin
    clr = '0;
    if (handshake) clr[ev_id] = 1'b1;
  end

  assign lost = rise & pending & ~clr;

  always_comb begin
    ovr_id_n = '0;
    for (int unsigned i = NU; i > 0; i--) begin
      if (lost[IDW'(i - 1)]) ovr_id_n = IDW'(i - 1);
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req  (pending),
    .last (last),
    .any  (any),
    .sel  (sel)
  );

  always_comb begin
    state_n = state;
    ev_id_n = ev_id;
    last_n  = last;
    gap_n   = gap_cnt;
    case (state)
      IDLE: begin
        if (any) begin
          ev_id_n = sel;
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          last_n = ev_id;
          if (MIN_GAP > 0) begin
            state_n = GAP;
            gap_n   = GAP_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      last     <= IDW'(N - 1);
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      ev_valid <= (state_n == OFFER);
      ev_id    <= ev_id_n;
      last     <= last_n;
      gap_cnt  <= gap_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1      <= '0;
      q2      <= '0;
      pending <= '0;
      overrun <= 1'b0;
      ovr_id  <= '0;
    end else begin
      q1      <= din;
      q2      <= q1;
      pending <= (pending & ~clr) | rise;
      overrun <= |lost;
      ovr_id  <= ovr_id_n;
    end
  end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Collects rising-edge events from N asynchronous-to-the-consumer level inputs (buttons, sensor-ready strobes, timer ticks) into per-source pending flags. It offers them one at a time to a single shared consumer, such as a UART command sender or a display updater, over a valid/ready handshake. Sources are served round-robin, with an optional enforced idle gap between grants. The block sits between the edge-detection front end and any one-request-at-a-time resource in the monitor datapath.

## Interface

- N, default 4: number of event sources (2..16).
- MIN_GAP, default 0: idle cycles forced after each accepted event (0..255).
- IDW, derived as $clog2(N): width of ev_id.

- clk, input, 1: single system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, N: level inputs, already synchronous to clk; a 0→1 transition is an event.
- ev_valid, output, 1: an event is offered on ev_id.
- ev_id, output, IDW: index of the offered source.
- ev_ready, input, 1: consumer accepts; a handshake occurs when ev_valid & ev_ready.
- pending, output, N: per-source pending flags.
- overrun, output, 1: one-cycle pulse when an event is lost.
- ovr_id, output, IDW: lowest-index source that lost an event that cycle.

## Operation

- **Edge detect.** Each bit i has two registers, q1[i] <= din[i] and q2[i] <= q1[i]. The edge is q1[i] & ~q2[i]. Both registers are cleared by rst. A din held high across reset release therefore yields exactly one event.
- **Pending.** An edge on i sets pending[i] at the next clk edge. A handshake on id i clears pending[i].
  - If an edge and the clearing handshake for the same i occur in the same cycle, the set wins: pending[i] stays 1 and no overrun is flagged.
- **Overrun.** An edge on i while pending[i]=1 and i is not being cleared that cycle drops the event. The next cycle, overrun=1 and ovr_id = the lowest such i. pending is unchanged.
- **FSM states** (the FSM encoding is shared via the package):
  - IDLE: if |pending, load ev_id = the first set bit searching from last+1 upward with wrap → OFFER. Otherwise stay in IDLE.
  - OFFER: ev_valid=1; ev_id is held stable until handshake. On handshake: last <= ev_id, then go to GAP if MIN_GAP>0 (gap counter loaded with MIN_GAP-1), else IDLE.
  - GAP: ev_valid=0; decrement the counter; at 0 → IDLE.
- **Round-robin pointer.** last resets to N-1, so source 0 has first priority after reset.
- **Consumer side.** ev_valid never drops without a handshake except on rst. The consumer may hold ev_ready high permanently.
- **Reset mid-operation.** All pending flags and the overrun flag clear, the FSM returns to IDLE, and any offered event is discarded.

## Timing

- **Reset values.** ev_valid=0, ev_id=0, pending=0, overrun=0, ovr_id=0, state=IDLE, last=N-1, gap counter=0.
- **Latency.** din[i] first sampled high at edge k → pending[i]=1 after edge k+1 → ev_valid=1, ev_id=i after edge k+2, assuming the FSM is in IDLE and no other source is pending.
- **Throughput.**
  - With MIN_GAP=0 and ev_ready tied high, one event is accepted every 2 cycles (OFFER→IDLE→OFFER).
  - With MIN_GAP=G, one event is accepted every G+2 cycles.
- **Registered outputs.** All outputs are registered; there is no combinational path from ev_ready to ev_valid or ev_id.
- **Events lost by construction.** Edges closer together than 2 cycles on the same source are filtered by the edge detector.

## Structure

- **Package pulse_scheduler_pkg:** typedef enum logic [1:0] {IDLE, OFFER, GAP} ps_state_t, plus the MIN_GAP counter width constant (8).
- **Sub-module rr_pick:** purely combinational round-robin selector. Inputs are req[N] and last[IDW]; outputs are any and sel[IDW].
- **pulse_scheduler** itself holds the edge registers, pending, the FSM, the gap counter and the overrun logic.

## Test plan

- **Single event, N=4, MIN_GAP=0, ev_ready=1.** Raise din[2] at edge 10 → ev_valid=1, ev_id=2 after edge 12. Handshake at edge 13. pending=0 after edge 13.
- **Round-robin.** Raise din[0], din[1] and din[3] in the same cycle with ev_ready=1 → grants in the order 0, 1, 3, spaced 2 cycles apart. Then raise din[0] and din[3] together with last=3 → order 0, 3.
- **Backpressure.** Hold ev_ready=0 for 20 cycles while din[1] is pending → ev_valid stays 1 and ev_id stays 1 throughout. Drop ev_ready low again after acceptance → the next grant starts cleanly.
- **Overrun and set-wins.**
  - Pulse din[2] twice, 4 cycles apart, with ev_ready=0 → one overrun pulse with ovr_id=2, and pending[2] stays 1.
  - Time a new din[2] edge to coincide with its own handshake → pending[2] remains 1, no overrun, and a second grant for id 2 follows.
- **MIN_GAP=3.** Two sources pending, ev_ready=1 → handshakes are 5 cycles apart, and ev_valid=0 during the 3 GAP cycles.
- **Reset.**
  - Assert rst for 1 cycle while in OFFER with pending=4'b1011 → all outputs return to their reset values at the next edge.
  - Hold din[0]=1 across reset release → exactly one grant for id 0.
